mem_stage: RTL and testbench

Memory-access stage of the ARM pipeline, between the EX/MEM register and `mem_stage_reg`. Issues loads and stores to data memory over a req/ready handshake and freezes the pipeline while an access is outstanding. Presents write-back enable, memory-read enable, ALU result, read data and destination to `mem_stage_reg`. Non-memory instructions pass through with zero latency.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_stage_watchdog.sv | 27 ++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory-access stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEST_W = 4;

endpackage

// File: rtl/mem_stage_watchdog.sv
// BUSY-cycle watchdog: counts stalled cycles and flags the last allowed one.
module mem_stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count_en)
            count <= count + CW'(1);
    end

    // Fires in the cycle whose stall would make the count reach the limit.
    assign expired = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ready data-memory access with pipeline freeze.
// Optional watchdog timeout enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Sig_Write_Back_Enable,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic                  i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_ALU_Result,
    input  logic [DATA_WIDTH-1:0] i_Store_Value,
    input  logic [DEST_W-1:0]     i_Destination,
    output logic                  o_Mem_Req,
    output logic                  o_Mem_We,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
    input  logic                  i_Mem_Ready,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
    output logic                  o_Freeze,
    output logic                  o_Mem_Error,
    output logic                  o_Sig_Write_Back_Enable,
    output logic                  o_Sig_Memory_Read_Enable,
    output logic [DATA_WIDTH-1:0] o_ALU_Result,
    output logic [DATA_WIDTH-1:0] o_Memory_Read_Value,
    output logic [DEST_W-1:0]     o_Destination
);

    mem_state_t state, state_nxt;

    logic                  access;
    logic                  launch;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign access = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
    assign busy   = (state == BUSY);
    assign done   = (state == DONE);
    assign launch = (state == IDLE) && access;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (access) state_nxt = BUSY;
            BUSY:    if (i_Mem_Ready || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Freeze-time bubbles keep mem_stage_reg from capturing a half-done op.
    always_comb begin
        o_Freeze                 = launch | busy;
        o_Sig_Write_Back_Enable  = i_Sig_Write_Back_Enable;
        o_Sig_Memory_Read_Enable = i_Sig_Memory_Read_Enable;
        o_Memory_Read_Value      = '0;
        if (done) begin
            o_Sig_Write_Back_Enable  = i_Sig_Write_Back_Enable & ~err;
            o_Sig_Memory_Read_Enable = i_Sig_Memory_Read_Enable & ~o_Mem_We;
            o_Memory_Read_Value      = rdata_q;
        end
        if (o_Freeze) begin
            o_Sig_Write_Back_Enable  = 1'b0;
            o_Sig_Memory_Read_Enable = 1'b0;
        end
    end

    assign o_ALU_Result  = i_ALU_Result;
    assign o_Destination = i_Destination;
    assign o_Mem_Error   = err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_Mem_Req   <= 1'b0;
            o_Mem_We    <= 1'b0;
            o_Mem_Addr  <= '0;
            o_Mem_Wdata <= '0;
            rdata_q     <= '0;
        end else if (launch) begin
            o_Mem_Req   <= 1'b1;
            o_Mem_We    <= i_Sig_Memory_Write_Enable;
            o_Mem_Addr  <= i_ALU_Result[ADDR_WIDTH-1:0];
            o_Mem_Wdata <= i_Store_Value;
            rdata_q     <= '0;
        end else if (busy && i_Mem_Ready) begin
            o_Mem_Req <= 1'b0;
            if (!o_Mem_We)
                rdata_q <= i_Mem_Rdata;
        end else if (busy && timeout) begin
            o_Mem_Req <= 1'b0;
        end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    logic expired;

    mem_stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (launch),
        .count_en (busy & ~i_Mem_Ready),
        .expired  (expired)
    );

    assign timeout = expired;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else
            err <= busy & timeout;
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wb, i_re, i_we;
    logic [31:0] i_alu, i_sv;
    logic [3:0]  i_dst;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        freeze, mem_err;
    logic        o_wb, o_re;
    logic [31:0] o_alu, o_rv;
    logic [3:0]  o_dst;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .i_Sig_Write_Back_Enable  (i_wb),
        .i_Sig_Memory_Read_Enable (i_re),
        .i_Sig_Memory_Write_Enable(i_we),
        .i_ALU_Result             (i_alu),
        .i_Store_Value            (i_sv),
        .i_Destination            (i_dst),
        .o_Mem_Req                (mem_req),
        .o_Mem_We                 (mem_we),
        .o_Mem_Addr               (mem_addr),
        .o_Mem_Wdata              (mem_wdata),
        .i_Mem_Ready              (mem_ready),
        .i_Mem_Rdata              (mem_rdata),
        .o_Freeze                 (freeze),
        .o_Mem_Error              (mem_err),
        .o_Sig_Write_Back_Enable  (o_wb),
        .o_Sig_Memory_Read_Enable (o_re),
        .o_ALU_Result             (o_alu),
        .o_Memory_Read_Value      (o_rv),
        .o_Destination            (o_dst)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Non-memory op: outputs mirror inputs in the same cycle, no freeze.
    task automatic pass_through(input logic wb, input logic [31:0] alu,
                                input logic [3:0] dst);
        i_wb = wb; i_re = 1'b0; i_we = 1'b0;
        i_alu = alu; i_sv = $urandom; i_dst = dst;
        mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
        #1;
        chk("pt_wb", 32'(o_wb), 32'(wb));
        chk("pt_alu", o_alu, alu);
        chk("pt_dst", 32'(o_dst), 32'(dst));
        chk("pt_freeze", 32'(freeze), 32'd0);
        chk("pt_rv", o_rv, 32'd0);
        @(negedge clk);
        chk("pt_req", 32'(mem_req), 32'd0);
        next_cycle();
    endtask

    // Memory op whose first ready arrives in BUSY cycle k.
    task automatic run_access(input logic wb, input logic re, input logic we,
                              input logic [31:0] alu, input logic [31:0] sv,
                              input logic [3:0] dst, input int k,
                              input logic [31:0] rd);
        i_wb = wb; i_re = re; i_we = we;
        i_alu = alu; i_sv = sv; i_dst = dst;
        mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
        @(negedge clk);
        chk("acc_freeze_n", 32'(freeze), 32'd1);
        chk("acc_req_n", 32'(mem_req), 32'd0);
        chk("acc_bubble_wb", 32'(o_wb), 32'd0);
        chk("acc_bubble_re", 32'(o_re), 32'd0);
        for (int j = 1; j <= k; j++) begin
            next_cycle();
            mem_ready = (j == k);
            mem_rdata = (j == k) ? rd : $urandom;
            @(negedge clk);
            chk("busy_req", 32'(mem_req), 32'd1);
            chk("busy_freeze", 32'(freeze), 32'd1);
            chk("busy_addr", mem_addr, alu);
            chk("busy_we", 32'(mem_we), 32'(we));
            chk("busy_wdata", mem_wdata, sv);
            chk("busy_wb", 32'(o_wb), 32'd0);
        end
        next_cycle();
        mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
        @(negedge clk);
        chk("done_freeze", 32'(freeze), 32'd0);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_wb", 32'(o_wb), 32'(wb));
        chk("done_re", 32'(o_re), 32'(re & ~we));
        chk("done_rv", o_rv, we ? 32'd0 : rd);
        chk("done_alu", o_alu, alu);
        chk("done_dst", 32'(o_dst), 32'(dst));
        chk("done_err", 32'(mem_err), 32'd0);
        next_cycle();
    endtask

    initial begin
        reset = 1'b0;
        i_wb = 1'b0; i_re = 1'b0; i_we = 1'b0;
        i_alu = '0; i_sv = '0; i_dst = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #2;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_rv", o_rv, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        pass_through(1'b1, 32'hABCD1234, 4'b1010);
        run_access(1'b1, 1'b1, 1'b0, 32'h00000040, 32'h0,
                   4'h3, 2, 32'h98765432);
        run_access(1'b0, 1'b0, 1'b1, 32'h00000080, 32'h55667788,
                   4'h0, 1, 32'hDEADBEEF);
        run_access(1'b1, 1'b1, 1'b1, 32'h00000100, 32'h11223344,
                   4'h7, 3, 32'hCAFEF00D);
        // Back-to-back: second op starts right after the first DONE.
        run_access(1'b1, 1'b1, 1'b0, 32'h00000200, 32'h0,
                   4'h5, 1, 32'h01020304);

        for (int t = 0; t < 40; t++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 0)
                pass_through(1'($urandom % 2), $urandom, 4'($urandom));
            else
                run_access(1'($urandom % 2), (op != 2), (op != 1),
                           $urandom, $urandom, 4'($urandom),
                           int'($urandom_range(1, TO)), $urandom);
        end

        // Reset dropped in the 2nd BUSY cycle; EX/MEM is reset alongside.
        i_wb = 1'b1; i_re = 1'b1; i_we = 1'b0;
        i_alu = 32'h00000444; i_dst = 4'h2; mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("mid_req_before", 32'(mem_req), 32'd1);
        #1;
        reset = 1'b0; i_re = 1'b0; i_we = 1'b0;
        #1;
        chk("mid_req_drop", 32'(mem_req), 32'd0);
        chk("mid_freeze_drop", 32'(freeze), 32'd0);
        chk("mid_addr_clr", mem_addr, 32'd0);
        chk("mid_rv_clr", o_rv, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        pass_through(1'b1, 32'hABCD1234, 4'b1010);

`ifdef MEM_STAGE_TIMEOUT_EN
        i_wb = 1'b1; i_re = 1'b1; i_we = 1'b0;
        i_alu = 32'h00000900; i_dst = 4'h9; mem_ready = 1'b0;
        @(negedge clk);
        chk("to_freeze_n", 32'(freeze), 32'd1);
        for (int j = 1; j <= TO; j++) begin
            next_cycle();
            mem_ready = 1'b0;
            @(negedge clk);
            chk("to_busy_req", 32'(mem_req), 32'd1);
            chk("to_busy_err", 32'(mem_err), 32'd0);
        end
        next_cycle();
        @(negedge clk);
        chk("to_done_err", 32'(mem_err), 32'd1);
        chk("to_done_wb", 32'(o_wb), 32'd0);
        chk("to_done_rv", o_rv, 32'd0);
        chk("to_done_freeze", 32'(freeze), 32'd0);
        chk("to_done_req", 32'(mem_req), 32'd0);
        next_cycle();
        i_re = 1'b0;
        @(negedge clk);
        chk("to_idle_err", 32'(mem_err), 32'd0);
        chk("to_idle_freeze", 32'(freeze), 32'd0);
        next_cycle();
        // Ready on the final allowed cycle still completes normally.
        run_access(1'b1, 1'b1, 1'b0, 32'h00000A00, 32'h0,
                   4'h4, TO, 32'h0BADF00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
